status_reg_file: RTL and testbench
==================================

Name: status_reg_file

Overview:
- Architectural 8-bit processor status register, feeding the status-load (LSTAT) data path stage directly downstream.
- Captures ALU condition flags each cycle and accepts whole-register writes from the 20-bit data bus (SSTAT) and single-bit set/clear ops.
- Provides a LIFO shadow stack for interrupt/call save and restore.
- The downstream stage zero-extends status_register onto the 20-bit bus; this block only owns the storage.

Parameters:
- STACK_DEPTH, 4, number of 8-bit shadow entries (power of two, 2..16).
- SP_W, $clog2(STACK_DEPTH)+1, stack pointer width (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flag_we  in  4  per-flag update mask for {V,N,Z,C}, bit 0 = C.
- alu_flags  in  4  ALU flag values {V,N,Z,C}.
- wr_en  in  1  whole-register write (SSTAT).
- wr_data  in  20  data bus; only [7:0] used, [19:8] ignored.
- bit_set  in  1  set status bit bit_idx.
- bit_clr  in  1  clear status bit bit_idx.
- bit_idx  in  3  target bit index for set/clear.
- push  in  1  save current status onto shadow stack.
- pop  in  1  restore status from shadow stack.
- err_clr  in  1  clear sticky error flags.
- status_register  out  8  live status: [0]C [1]Z [2]N [3]V [4]I (interrupt enable) [7:5] general flags.
- stack_empty  out  1  stack holds 0 entries.
- stack_full  out  1  stack holds STACK_DEPTH entries.
- stack_ovf  out  1  sticky: push attempted while full.
- stack_unf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, rst_n=0):
  - status_register=8'h00, stack pointer=0, stack_empty=1, stack_full=0, stack_ovf=0, stack_unf=0.
  - Stack contents need not be cleared.
- All updates occur on rising clk edge. status_register is registered: a change is visible the cycle after the request.
- Next-value priority, highest first:
  1. Valid pop: status_register <= top entry; sp-1. All other writes that cycle are dropped.
  2. wr_en: status_register <= wr_data[7:0].
  3. bit_set/bit_clr on bit_idx. Both asserted together: no change to that bit.
  4. flag_we: each masked bit takes alu_flags; unmasked bits hold.
- Items 3 and 4 merge when they touch different bits. Same bit: bit op wins.
- Push:
  - Stores the pre-edge status_register at entry[sp]; sp+1.
  - Live-register updates from items 2-4 still apply in the same cycle.
- push and pop in the same cycle:
  - Both ignored; sp unchanged.
  - Live register updated per items 2-4 only.
  - No error flag set.
- Push while full: no store, sp holds, stack_ovf<=1.
- Pop while empty: no restore, sp holds, stack_unf<=1. Items 2-4 still apply.
- stack_ovf and stack_unf stay set until err_clr or reset.
  - err_clr in the same cycle as a new error: error wins (flag stays 1).
- stack_empty = (sp==0); stack_full = (sp==STACK_DEPTH). Both decode combinationally from registered sp.
- Stack is strict LIFO. Sequence push A, push B, pop, pop restores B then A.

Optional Feature:
- Macro: STATUS_AUTO_IMASK_EN.
- Defined:
  - A valid push also clears bit 4 (I) of the live register that same edge.
  - The pre-clear value is what gets saved, so a later pop restores the original I.
  - The I clear overrides items 2-4 for bit 4.
- Undefined: push never modifies the live register.

Test Plan:
- Reset: hold rst_n=0 mid-stream with status=8'h5A, sp=2 -> status_register=8'h00, stack_empty=1, no clk edge required.
- Flag mask: status=8'hF0, flag_we=4'b0101, alu_flags=4'b1111 -> next cycle status=8'hF5.
- Priority: wr_en with wr_data=20'hABC3C, bit_set idx 7, and flag_we=4'hF all in one cycle -> status=8'h3C.
- LIFO: push 8'h11, write 8'h22, push, write 8'h33, pop, pop -> status 8'h22 then 8'h11; stack_empty=1 after second pop.
- Overflow: STACK_DEPTH=4, 5 pushes -> stack_full=1 after 4th, stack_ovf=1 after 5th, sp stays 4. Pop while empty -> stack_unf=1. err_clr -> both flags 0.
- Auto-imask (macro defined): status=8'h10, push -> status=8'h00; pop -> status=8'h10. Macro undefined: status stays 8'h10 after push.

Source files
------------

// File: rtl/status_reg_file_if.sv
// Bus bundle for status_reg_file: flag/write/bit/stack requests in,
// live status and stack state out.
interface status_reg_file_if;
  logic [3:0]  flag_we;
  logic [3:0]  alu_flags;
  logic        wr_en;
  logic [19:0] wr_data;
  logic        bit_set;
  logic        bit_clr;
  logic [2:0]  bit_idx;
  logic        push;
  logic        pop;
  logic        err_clr;
  logic [7:0]  status_register;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_ovf;
  logic        stack_unf;

  modport master (
    output flag_we, alu_flags, wr_en, wr_data, bit_set, bit_clr, bit_idx,
           push, pop, err_clr,
    input  status_register, stack_empty, stack_full, stack_ovf, stack_unf
  );

  modport slave (
    input  flag_we, alu_flags, wr_en, wr_data, bit_set, bit_clr, bit_idx,
           push, pop, err_clr,
    output status_register, stack_empty, stack_full, stack_ovf, stack_unf
  );
endinterface

// File: rtl/status_reg_file.sv
// 8-bit processor status register with LIFO shadow stack and sticky stack errors.
// Optional STATUS_AUTO_IMASK_EN: a valid push also clears the live I bit (bit 4).
module status_reg_file #(
  parameter  int STACK_DEPTH = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input logic             clk,
  input logic             rst_n,
  status_reg_file_if.slave bus
);
  localparam int IDX_W = SP_W - 1;

  logic [7:0]      status_q, status_d, live_upd;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [7:0]      stack_mem [STACK_DEPTH];
  logic            ovf_q, unf_q;
  logic            empty, full;
  logic            push_req, pop_req, push_ok, pop_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic            unused_wr_hi;

  assign unused_wr_hi = ^bus.wr_data[19:8];

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_W'(STACK_DEPTH));

  // simultaneous push and pop cancel each other without raising errors
  assign push_req = bus.push & ~bus.pop;
  assign pop_req  = bus.pop  & ~bus.push;
  assign push_ok  = push_req & ~full;
  assign pop_ok   = pop_req  & ~empty;

  assign wr_idx = sp_q[IDX_W-1:0];
  assign rd_idx = IDX_W'(sp_q - 1'b1);

  always_comb begin
    live_upd = status_q;
    if (bus.wr_en) begin
      live_upd = bus.wr_data[7:0];
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.flag_we[i]) live_upd[i] = bus.alu_flags[i];
      // bit op lands after the flag merge so it wins on a shared bit
      if (bus.bit_set ^ bus.bit_clr) live_upd[bus.bit_idx] = bus.bit_set;
    end
`ifdef STATUS_AUTO_IMASK_EN
    if (push_ok) live_upd[4] = 1'b0;
`endif
    status_d = pop_ok ? stack_mem[rd_idx] : live_upd;
  end

  always_comb begin
    sp_d = sp_q;
    if (push_ok)     sp_d = sp_q + 1'b1;
    else if (pop_ok) sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 8'h00;
      sp_q     <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      sp_q     <= sp_d;
      if (push_req && full)  ovf_q <= 1'b1;
      else if (bus.err_clr)  ovf_q <= 1'b0;
      if (pop_req && empty)  unf_q <= 1'b1;
      else if (bus.err_clr)  unf_q <= 1'b0;
    end
  end

  // shadow entries hold whatever was last saved; reset only empties the pointer
  always_ff @(posedge clk) begin
    if (push_ok) stack_mem[wr_idx] <= status_q;
  end

  assign bus.status_register = status_q;
  assign bus.stack_empty     = empty;
  assign bus.stack_full      = full;
  assign bus.stack_ovf       = ovf_q;
  assign bus.stack_unf       = unf_q;
endmodule

// File: tb/tb_status_reg_file.sv
// Directed vector bench for status_reg_file (STACK_DEPTH=4).
module tb_status_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef STATUS_AUTO_IMASK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  status_reg_file_if bus ();
  status_reg_file #(.STACK_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flag_we;
    logic [3:0]  alu;
    logic        wr_en;
    logic [19:0] wr_data;
    logic        bset;
    logic        bclr;
    logic [2:0]  idx;
    logic        push;
    logic        pop;
    logic        eclr;
    logic [7:0]  exp_st;
    logic [3:0]  exp_fl;   // {empty, full, ovf, unf}
  } vec_t;

  function automatic vec_t mk(logic [3:0] fw, logic [3:0] alu, logic we, logic [19:0] wd,
                              logic bs, logic bc, logic [2:0] ix, logic pu, logic po,
                              logic ec, logic [7:0] es, logic [3:0] ef);
    vec_t v;
    v.flag_we = fw; v.alu = alu; v.wr_en = we; v.wr_data = wd;
    v.bset = bs; v.bclr = bc; v.idx = ix; v.push = pu; v.pop = po; v.eclr = ec;
    v.exp_st = es; v.exp_fl = ef;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_all(string name, logic [7:0] st, logic [3:0] fl);
    check({name, " status"}, bus.status_register, st);
    check({name, " flags"},
          {4'h0, bus.stack_empty, bus.stack_full, bus.stack_ovf, bus.stack_unf}, {4'h0, fl});
  endtask

  task automatic idle();
    bus.flag_we = '0; bus.alu_flags = '0; bus.wr_en = 1'b0; bus.wr_data = '0;
    bus.bit_set = 1'b0; bus.bit_clr = 1'b0; bus.bit_idx = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic apply(vec_t v);
    bus.flag_we = v.flag_we; bus.alu_flags = v.alu; bus.wr_en = v.wr_en;
    bus.wr_data = v.wr_data; bus.bit_set = v.bset; bus.bit_clr = v.bclr;
    bus.bit_idx = v.idx; bus.push = v.push; bus.pop = v.pop; bus.err_clr = v.eclr;
    @(posedge clk);
    #1;
    idle();
  endtask

  vec_t tbl [29];

  initial begin
    idle();
    //            fw     alu    we  wdata      bs  bc  ix    pu  po  ec  exp_st                    exp_fl
    tbl[0]  = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  0,  0,  8'h00,                    4'b1000);
    tbl[1]  = mk(4'h0, 4'h0, 1, 20'h000F0, 0,  0,  3'd0, 0,  0,  0,  8'hF0,                    4'b1000);
    tbl[2]  = mk(4'h5, 4'hF, 0, 20'h0,     0,  0,  3'd0, 0,  0,  0,  8'hF5,                    4'b1000);
    tbl[3]  = mk(4'hF, 4'hF, 1, 20'hABC3C, 1,  0,  3'd7, 0,  0,  0,  8'h3C,                    4'b1000);
    tbl[4]  = mk(4'h7, 4'h0, 0, 20'h0,     1,  0,  3'd0, 0,  0,  0,  8'h39,                    4'b1000);
    tbl[5]  = mk(4'h0, 4'h0, 0, 20'h0,     1,  1,  3'd3, 0,  0,  0,  8'h39,                    4'b1000);
    tbl[6]  = mk(4'h0, 4'h0, 0, 20'h0,     0,  1,  3'd5, 0,  0,  0,  8'h19,                    4'b1000);
    tbl[7]  = mk(4'h0, 4'h0, 1, 20'h00011, 0,  0,  3'd0, 0,  0,  0,  8'h11,                    4'b1000);
    tbl[8]  = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 1,  0,  0,  AUTO ? 8'h01 : 8'h11,     4'b0000);
    tbl[9]  = mk(4'h0, 4'h0, 1, 20'h00022, 0,  0,  3'd0, 0,  0,  0,  8'h22,                    4'b0000);
    tbl[10] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 1,  0,  0,  8'h22,                    4'b0000);
    tbl[11] = mk(4'h0, 4'h0, 1, 20'h00033, 0,  0,  3'd0, 0,  0,  0,  8'h33,                    4'b0000);
    tbl[12] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  1,  0,  8'h22,                    4'b0000);
    tbl[13] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  1,  0,  8'h11,                    4'b1000);
    tbl[14] = mk(4'h0, 4'h0, 1, 20'h00000, 0,  0,  3'd0, 0,  0,  0,  8'h00,                    4'b1000);
    tbl[15] = mk(4'h0, 4'h0, 1, 20'h0000A, 0,  0,  3'd0, 1,  0,  0,  8'h0A,                    4'b0000);
    tbl[16] = mk(4'h0, 4'h0, 1, 20'h0000B, 0,  0,  3'd0, 1,  0,  0,  8'h0B,                    4'b0000);
    tbl[17] = mk(4'h0, 4'h0, 1, 20'h0000C, 0,  0,  3'd0, 1,  0,  0,  8'h0C,                    4'b0000);
    tbl[18] = mk(4'h0, 4'h0, 1, 20'h0000D, 0,  0,  3'd0, 1,  0,  0,  8'h0D,                    4'b0100);
    tbl[19] = mk(4'h0, 4'h0, 1, 20'h0000E, 0,  0,  3'd0, 1,  0,  0,  8'h0E,                    4'b0110);
    tbl[20] = mk(4'hF, 4'hF, 1, 20'h000FF, 0,  0,  3'd0, 0,  1,  0,  8'h0C,                    4'b0010);
    tbl[21] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  1,  0,  8'h0B,                    4'b0010);
    tbl[22] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  1,  0,  8'h0A,                    4'b0010);
    tbl[23] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  1,  0,  8'h00,                    4'b1010);
    tbl[24] = mk(4'h0, 4'h0, 0, 20'h0,     1,  0,  3'd6, 0,  1,  0,  8'h40,                    4'b1011);
    tbl[25] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  0,  1,  8'h40,                    4'b1000);
    tbl[26] = mk(4'h0, 4'h0, 0, 20'h0,     1,  0,  3'd1, 1,  1,  0,  8'h42,                    4'b1000);
    tbl[27] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  1,  1,  8'h42,                    4'b1001);
    tbl[28] = mk(4'h0, 4'h0, 0, 20'h0,     0,  0,  3'd0, 0,  0,  1,  8'h42,                    4'b1000);

    @(posedge clk);
    #1;
    check_all("reset", 8'h00, 4'b1000);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      apply(tbl[i]);
      check_all($sformatf("vec%0d", i), tbl[i].exp_st, tbl[i].exp_fl);
    end

    // async reset mid-stream with status 5A and two entries stacked
    apply(mk(4'h0, 4'h0, 0, 20'h0, 0, 0, 3'd0, 1, 0, 0, 8'h00, 4'b0000));
    apply(mk(4'h0, 4'h0, 0, 20'h0, 0, 0, 3'd0, 1, 0, 0, 8'h00, 4'b0000));
    apply(mk(4'h0, 4'h0, 1, 20'h0005A, 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'b0000));
    check_all("pre_rst", 8'h5A, 4'b0000);
    rst_n = 1'b0;
    #2;
    check_all("async_rst", 8'h00, 4'b1000);
    #1;
    rst_n = 1'b1;

    // I bit handling across push/pop
    apply(mk(4'h0, 4'h0, 1, 20'h00010, 0, 0, 3'd0, 0, 0, 0, 8'h00, 4'b0000));
    check_all("imask_set", 8'h10, 4'b1000);
    apply(mk(4'h0, 4'h0, 0, 20'h0, 0, 0, 3'd0, 1, 0, 0, 8'h00, 4'b0000));
    check_all("imask_push", AUTO ? 8'h00 : 8'h10, 4'b0000);
    apply(mk(4'h0, 4'h0, 0, 20'h0, 0, 0, 3'd0, 0, 1, 0, 8'h00, 4'b0000));
    check_all("imask_pop", 8'h10, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
